// File: rtl/multi_strb_gen.sv
// Multi-channel programmable strobe generator: per-channel clock divider with a one-cycle
// strobe, a square-wave toggle, and divisor updates deferred to period boundaries.
module multi_strb_gen #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16,
    parameter int RST_DIV = 2
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,
    input  logic [NUM_CH-1:0]         en_i,
    input  logic [NUM_CH*CNT_W-1:0]   div_i,
    input  logic [NUM_CH-1:0]         div_load_i,
    input  logic                      sync_i,
    output logic [NUM_CH-1:0]         strb_o,
    output logic [NUM_CH-1:0]         tgl_o,
    output logic [NUM_CH-1:0]         pend_o
);

    localparam logic [CNT_W-1:0] RST_DIV_V = CNT_W'(RST_DIV);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] pend_val_q;
        logic             pend_q;
        logic             strb_q;
        logic             tgl_q;
        logic [CNT_W-1:0] div_new;
        logic [CNT_W-1:0] last_cnt;
        logic             tc;
        logic             boundary;
        logic             fire;

        assign div_new  = div_i[c*CNT_W +: CNT_W];
        // A programmed divisor of 0 behaves as 1, so the last count is 0 in both cases.
        assign last_cnt = (div_q == '0) ? '0 : div_q - ONE;
        assign tc       = en_i[c] & (cnt_q == last_cnt);
        assign boundary = tc | sync_i | ~en_i[c];
        assign fire     = tc & ~sync_i;

        always_ff @(posedge clk_i or negedge arstn_i) begin
            if (!arstn_i) begin
                cnt_q      <= '0;
                div_q      <= RST_DIV_V;
                pend_val_q <= '0;
                pend_q     <= 1'b0;
                strb_q     <= 1'b0;
                tgl_q      <= 1'b0;
            end else begin
                if (sync_i || !en_i[c] || tc) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + ONE;
                end

                strb_q <= fire;
                tgl_q  <= tgl_q ^ fire;

                // A fresh load always supersedes whatever was pending.
                if (div_load_i[c]) begin
                    if (boundary) begin
                        div_q  <= div_new;
                        pend_q <= 1'b0;
                    end else begin
                        pend_val_q <= div_new;
                        pend_q     <= 1'b1;
                    end
                end else if (pend_q && boundary) begin
                    div_q  <= pend_val_q;
                    pend_q <= 1'b0;
                end
            end
        end

        assign strb_o[c] = strb_q;
        assign tgl_o[c]  = tgl_q;
        assign pend_o[c] = pend_q;
    end

endmodule

// File: tb/tb_multi_strb_gen.sv
// Directed bench for multi_strb_gen: hand-derived strobe/pending edge lists feed a
// scoreboard queue that is checked one cycle at a time against the DUT outputs.
module tb_multi_strb_gen;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 16;
    localparam int LAST_E = 74;

    logic                    clk_i = 1'b0;
    logic                    arstn_i;
    logic [NUM_CH-1:0]       en_i;
    logic [NUM_CH*CNT_W-1:0] div_i;
    logic [NUM_CH-1:0]       div_load_i;
    logic                    sync_i;
    logic [NUM_CH-1:0]       strb_o;
    logic [NUM_CH-1:0]       tgl_o;
    logic [NUM_CH-1:0]       pend_o;

    multi_strb_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_DIV(2)) dut (
        .clk_i      (clk_i),
        .arstn_i    (arstn_i),
        .en_i       (en_i),
        .div_i      (div_i),
        .div_load_i (div_load_i),
        .sync_i     (sync_i),
        .strb_o     (strb_o),
        .tgl_o      (tgl_o),
        .pend_o     (pend_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int       edge_n;
        logic [1:0] strb;
        logic [1:0] tgl;
        logic [1:0] pend;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [1:0] exp_tgl = 2'b00;

    task automatic push_exp(input int e, input logic [1:0] s, input logic [1:0] p);
        exp_t x;
        exp_tgl  = exp_tgl ^ s;
        x.edge_n = e;
        x.strb   = s;
        x.tgl    = exp_tgl;
        x.pend   = p;
        sb.push_back(x);
    endtask

    task automatic pop_check();
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=0 entries required=1");
            return;
        end
        x = sb.pop_front();
        assert (strb_o === x.strb) else begin
            errors++;
            $error("FAIL e%0d strb observed=%b expected=%b", x.edge_n, strb_o, x.strb);
        end
        checks++;
        assert (tgl_o === x.tgl) else begin
            errors++;
            $error("FAIL e%0d tgl observed=%b expected=%b", x.edge_n, tgl_o, x.tgl);
        end
        checks++;
        assert (pend_o === x.pend) else begin
            errors++;
            $error("FAIL e%0d pend observed=%b expected=%b", x.edge_n, pend_o, x.pend);
        end
    endtask

    task automatic set_div(input int d0, input int d1);
        div_i[0*CNT_W +: CNT_W] = CNT_W'(d0);
        div_i[1*CNT_W +: CNT_W] = CNT_W'(d1);
    endtask

    initial begin
        logic [1:0] s;
        logic [1:0] p;

        arstn_i    = 1'b0;
        en_i       = 2'b11;
        div_i      = '0;
        div_load_i = 2'b00;
        sync_i     = 1'b0;
        #2;
        push_exp(0, 2'b00, 2'b00);
        pop_check();
        @(posedge clk_i);
        #1;
        arstn_i = 1'b1;

        for (int e = 1; e <= LAST_E; e++) begin
            en_i       = 2'b11;
            div_load_i = 2'b00;
            sync_i     = 1'b0;
            set_div(0, 0);
            case (e)
                7:          begin div_load_i = 2'b01; set_div(5, 0); end
                19:         begin en_i = 2'b01; div_load_i = 2'b10; set_div(0, 10); end
                22:         begin div_load_i = 2'b10; set_div(0, 7); end
                24:         begin div_load_i = 2'b10; set_div(0, 3); end
                39:         begin sync_i = 1'b1; div_load_i = 2'b11; set_div(4, 6); end
                47:         sync_i = 1'b1;
                60:         begin sync_i = 1'b1; div_load_i = 2'b11; set_div(0, 1); end
                65:         begin div_load_i = 2'b01; set_div(4, 0); end
                67, 68, 69: en_i = 2'b10;
                default:    ;
            endcase

            s[0] = e inside {2, 4, 6, 8, 13, 18, 23, 28, 33, 38, 43, 51, 55, 59,
                             [61:65], 73};
            s[1] = e inside {2, 4, 6, 8, 10, 12, 14, 16, 18, 29, 32, 35, 38,
                             45, 53, 59, [61:74]};
            p[0] = e inside {7};
            p[1] = e inside {[22:28]};
            push_exp(e, s, p);

            @(posedge clk_i);
            #1;
            pop_check();
        end

        // Asynchronous reset in the middle of a ch0 period (cnt0 = 1 here).
        #3;
        arstn_i = 1'b0;
        #1;
        exp_tgl = 2'b00;
        push_exp(100, 2'b00, 2'b00);
        pop_check();
        #2;
        arstn_i = 1'b1;

        // Both divisors are back at the reset value of 2.
        for (int r = 1; r <= 4; r++) begin
            en_i       = 2'b11;
            div_load_i = 2'b00;
            sync_i     = 1'b0;
            push_exp(100 + r, (r % 2 == 0) ? 2'b11 : 2'b00, 2'b00);
            @(posedge clk_i);
            #1;
            pop_check();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
